// File: rtl/alu_pkg.sv
// Shared types for the ALU flag consumer: branch kinds, ARM condition codes,
// the NZCV flag word and the branch-resolution FSM encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_CBZ    = 2'b01,
    BR_CBNZ   = 2'b10,
    BR_UNCOND = 2'b11
  } br_type_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam logic [1:0] FSM_IDLE    = 2'b00;
  localparam logic [1:0] FSM_WAIT    = 2'b01;
  localparam logic [1:0] FSM_RESOLVE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = FSM_IDLE,
    ST_WAIT    = FSM_WAIT,
    ST_RESOLVE = FSM_RESOLVE
  } state_t;

endpackage

// File: rtl/alu_flag_unit_cond_eval.sv
// Combinational ARMv8 condition-code evaluator: NZCV flags + condition -> taken.
module cond_eval
  import alu_pkg::*;
(
  input  nzcv_t flags,
  input  cond_t cond,
  output logic  taken
);

  logic ge;
  logic hi;
  logic gt;

  assign ge = (flags.n == flags.v);
  assign hi = flags.c & ~flags.z;
  assign gt = ~flags.z & ge;

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flags.z;
      COND_NE: taken = ~flags.z;
      COND_HS: taken = flags.c;
      COND_LO: taken = ~flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = ~flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = ~flags.v;
      COND_HI: taken = hi;
      COND_LS: taken = ~hi;
      COND_GE: taken = ge;
      COND_LT: taken = ~ge;
      COND_GT: taken = gt;
      COND_LE: taken = ~gt;
      // ARMv8 treats NV as always, same as AL
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Architectural NZCV capture and conditional-branch resolution with a
// valid/ready request side. Optional counters enabled by BR_STATS_EN.
module alu_flag_unit
  import alu_pkg::*;
`ifdef BR_STATS_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic       negative,
  input  logic       zero,
  input  logic       overflow,
  input  logic       carry_out,
  input  logic       set_flags,
  input  logic       flags_pending,
  input  logic       br_valid,
  output logic       br_ready,
  input  logic [1:0] br_type,
  input  logic [3:0] br_cond,
  input  logic       reg_zero,
  output logic       res_valid,
  output logic       taken,
  output logic [3:0] flags_q
`ifdef BR_STATS_EN
  ,
  output logic [CNT_W-1:0] resolved_count,
  output logic [CNT_W-1:0] taken_count
`endif
);

  state_t   state_q;
  nzcv_t    flags_r;
  nzcv_t    live_flags;
  nzcv_t    eff_flags;
  br_type_t type_p0;
  cond_t    cond_p0;
  logic     rzero_p0;

  br_type_t type_sel;
  cond_t    cond_sel;
  logic     rzero_sel;
  logic     cond_taken;
  logic     resolve_taken;
  logic     go_wait;

  assign live_flags = '{n: negative, z: zero, c: carry_out, v: overflow};
  // Same-cycle set_flags bypasses the register so a branch sees the newest flags
  assign eff_flags  = set_flags ? live_flags : flags_r;
  assign flags_q    = flags_r;
  assign br_ready   = reset && (state_q == ST_IDLE);

  // In IDLE the request is evaluated straight off the ports; later from the capture
  always_comb begin
    type_sel  = type_p0;
    cond_sel  = cond_p0;
    rzero_sel = rzero_p0;
    if (state_q == ST_IDLE) begin
      type_sel  = br_type_t'(br_type);
      cond_sel  = cond_t'(br_cond);
      rzero_sel = reg_zero;
    end
  end

  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (cond_sel),
    .taken (cond_taken)
  );

  always_comb begin
    resolve_taken = 1'b0;
    case (type_sel)
      BR_COND:   resolve_taken = cond_taken;
      BR_CBZ:    resolve_taken = rzero_sel;
      BR_CBNZ:   resolve_taken = ~rzero_sel;
      BR_UNCOND: resolve_taken = 1'b1;
      default:   resolve_taken = 1'b0;
    endcase
  end

  assign go_wait = (br_type_t'(br_type) == BR_COND) && flags_pending && !set_flags;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      flags_r   <= '0;
      res_valid <= 1'b0;
      taken     <= 1'b0;
      type_p0   <= BR_COND;
      cond_p0   <= COND_EQ;
      rzero_p0  <= 1'b0;
    end else begin
      if (set_flags) flags_r <= live_flags;
      res_valid <= 1'b0;
      taken     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (br_valid) begin
            type_p0  <= br_type_t'(br_type);
            cond_p0  <= cond_t'(br_cond);
            rzero_p0 <= reg_zero;
            if (go_wait) begin
              state_q <= ST_WAIT;
            end else begin
              state_q   <= ST_RESOLVE;
              res_valid <= 1'b1;
              taken     <= resolve_taken;
            end
          end
        end
        ST_WAIT: begin
          if (set_flags || !flags_pending) begin
            state_q   <= ST_RESOLVE;
            res_valid <= 1'b1;
            taken     <= resolve_taken;
          end
        end
        ST_RESOLVE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      resolved_count <= '0;
      taken_count    <= '0;
    end else if (res_valid) begin
      resolved_count <= resolved_count + 1'b1;
      if (taken) taken_count <= taken_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: flag capture, condition codes, bypass,
// WAIT handling, CBZ/CBNZ/B and reset during a pending request.
module tb_alu_flag_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       negative, zero, overflow, carry_out;
  logic       set_flags, flags_pending;
  logic       br_valid;
  logic       br_ready;
  logic [1:0] br_type;
  logic [3:0] br_cond;
  logic       reg_zero;
  logic       res_valid;
  logic       taken;
  logic [3:0] flags_q;
`ifdef BR_STATS_EN
  logic [31:0] resolved_count, taken_count;
  logic [31:0] res_base, tkn_base;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_flag_unit dut (
    .clk           (clk),
    .reset         (reset),
    .negative      (negative),
    .zero          (zero),
    .overflow      (overflow),
    .carry_out     (carry_out),
    .set_flags     (set_flags),
    .flags_pending (flags_pending),
    .br_valid      (br_valid),
    .br_ready      (br_ready),
    .br_type       (br_type),
    .br_cond       (br_cond),
    .reg_zero      (reg_zero),
    .res_valid     (res_valid),
    .taken         (taken),
    .flags_q       (flags_q)
`ifdef BR_STATS_EN
    ,
    .resolved_count(resolved_count),
    .taken_count   (taken_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic sf, input logic n, input logic z, input logic c, input logic v);
    set_flags = sf; negative = n; zero = z; carry_out = c; overflow = v;
  endtask

  task automatic req(input logic [1:0] t, input logic [3:0] c, input logic rz);
    br_valid = 1'b1; br_type = t; br_cond = c; reg_zero = rz;
  endtask

  initial begin
    reset = 1'b0;
    set_alu(0, 0, 0, 0, 0);
    flags_pending = 1'b0;
    br_valid = 1'b0; br_type = 2'b00; br_cond = 4'd0; reg_zero = 1'b0;

    // 1: reset held two cycles
    tick(); tick();
    chk("rst_flags_q", 32'(flags_q), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_br_ready", 32'(br_ready), 32'h0);
    reset = 1'b1;
    #1;
    chk("post_rst_br_ready", 32'(br_ready), 32'h1);

    // 2: N=1 -> LT taken, GE not taken
    set_alu(1, 1, 0, 0, 0);
    tick();
    set_alu(0, 0, 0, 0, 0);
    chk("flags_n", 32'(flags_q), 32'h8);
    req(2'b00, 4'd11, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("lt_res_valid", 32'(res_valid), 32'h1);
    chk("lt_taken", 32'(taken), 32'h1);
    chk("lt_resolve_ready", 32'(br_ready), 32'h0);
    tick();
    chk("lt_pulse_end", 32'(res_valid), 32'h0);
    chk("lt_ready_again", 32'(br_ready), 32'h1);
    req(2'b00, 4'd10, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("ge_res_valid", 32'(res_valid), 32'h1);
    chk("ge_taken", 32'(taken), 32'h0);
    tick();

    // 3: EQ while flags pending -> WAIT, then set_flags with Z=1
    flags_pending = 1'b1;
    req(2'b00, 4'd0, 1'b0);
    tick();
    br_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_br_ready", 32'(br_ready), 32'h0);
      chk("wait_res_valid", 32'(res_valid), 32'h0);
      if (i < 2) tick();
    end
    set_alu(1, 0, 1, 0, 0);
    tick();
    set_alu(0, 0, 0, 0, 0);
    flags_pending = 1'b0;
    chk("eq_wait_res_valid", 32'(res_valid), 32'h1);
    chk("eq_wait_taken", 32'(taken), 32'h1);
    chk("eq_wait_flags", 32'(flags_q), 32'h4);
    tick();

    // 4: same-cycle set_flags Z=1,C=1 with HI -> not taken
    set_alu(1, 0, 1, 1, 0);
    req(2'b00, 4'd8, 1'b0);
    tick();
    set_alu(0, 0, 0, 0, 0);
    br_valid = 1'b0;
    chk("hi_bypass_res_valid", 32'(res_valid), 32'h1);
    chk("hi_bypass_taken", 32'(taken), 32'h0);
    chk("hi_bypass_flags", 32'(flags_q), 32'h6);
    tick();
    // stored C=1, live C=0: LO must follow the live value
    set_alu(1, 0, 0, 0, 0);
    req(2'b00, 4'd3, 1'b0);
    tick();
    set_alu(0, 0, 0, 0, 0);
    br_valid = 1'b0;
    chk("lo_bypass_taken", 32'(taken), 32'h1);
    chk("lo_bypass_flags", 32'(flags_q), 32'h0);
    tick();
    // NV behaves as always
    req(2'b00, 4'd15, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("nv_taken", 32'(taken), 32'h1);
    tick();

    // 5: CBZ / CBNZ / B ignore flags_pending
`ifdef BR_STATS_EN
    res_base = resolved_count;
    tkn_base = taken_count;
`endif
    flags_pending = 1'b1;
    req(2'b01, 4'd0, 1'b1);
    tick();
    br_valid = 1'b0;
    chk("cbz_res_valid", 32'(res_valid), 32'h1);
    chk("cbz_taken", 32'(taken), 32'h1);
    tick();
    req(2'b10, 4'd0, 1'b1);
    tick();
    br_valid = 1'b0;
    chk("cbnz_res_valid", 32'(res_valid), 32'h1);
    chk("cbnz_taken", 32'(taken), 32'h0);
    tick();
    req(2'b11, 4'd0, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("b_res_valid", 32'(res_valid), 32'h1);
    chk("b_taken", 32'(taken), 32'h1);
    tick();
    flags_pending = 1'b0;
`ifdef BR_STATS_EN
    chk("stats_resolved", resolved_count - res_base, 32'd3);
    chk("stats_taken", taken_count - tkn_base, 32'd2);
`endif

    // 6a: reset during WAIT drops the request
    set_alu(1, 1, 0, 0, 0);
    tick();
    set_alu(0, 0, 0, 0, 0);
    flags_pending = 1'b1;
    req(2'b00, 4'd4, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("pre_rst_wait_ready", 32'(br_ready), 32'h0);
    reset = 1'b0;
    tick();
    chk("midrst_res_valid", 32'(res_valid), 32'h0);
    chk("midrst_flags", 32'(flags_q), 32'h0);
    reset = 1'b1;
    flags_pending = 1'b0;
    #1;
    chk("midrst_idle_ready", 32'(br_ready), 32'h1);
    tick();
    chk("midrst_no_pulse", 32'(res_valid), 32'h0);

    // 6b: flags_pending drops without set_flags -> use stored V=1 for VS
    set_alu(1, 0, 0, 0, 1);
    tick();
    set_alu(0, 0, 0, 0, 0);
    chk("flags_v", 32'(flags_q), 32'h1);
    flags_pending = 1'b1;
    req(2'b00, 4'd6, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("vs_wait_ready", 32'(br_ready), 32'h0);
    tick();
    chk("vs_still_wait", 32'(res_valid), 32'h0);
    flags_pending = 1'b0;
    tick();
    chk("vs_drop_res_valid", 32'(res_valid), 32'h1);
    chk("vs_drop_taken", 32'(taken), 32'h1);
    tick();
    chk("vs_pulse_end", 32'(res_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
